// File: rtl/convolution_weight_loader.sv
// Run-time loader for convolution kernel weights: a serial AXI-Stream fills a shadow bank,
// which is committed to the active bank on a frame boundary. Option: CONV_WEIGHT_IDENTITY_RESET_EN.
module convolution_weight_loader #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int IN_CHANNELS  = 3,
  parameter int OUT_CHANNELS = 3
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic slave_tvalid_i,
  output logic slave_tready_o,
  input  logic signed [WEIGHT_WIDTH-1:0] slave_tdata_i,
  input  logic slave_tlast_i,
  input  logic frame_end_i,
  output logic signed [OUT_CHANNELS-1:0][IN_CHANNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WEIGHT_WIDTH-1:0] weight_o,
  output logic busy_o,
  output logic pending_o,
  output logic commit_o,
  output logic error_o
);

  localparam int NumWeights = OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
  localparam int CountWidth = $clog2(NumWeights + 1);
  localparam int BankWidth  = NumWeights * WEIGHT_WIDTH;
  localparam logic [CountWidth-1:0] LastIdx = CountWidth'(NumWeights - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    PENDING
  } state_e;

  // Word n of the stream lives at bits [n*WEIGHT_WIDTH +: WEIGHT_WIDTH], matching the packed
  // layout of weight_o with out_channel most significant and column least significant.
  function automatic logic [BankWidth-1:0] default_bank();
    logic [BankWidth-1:0] bank;
    bank = '0;
`ifdef CONV_WEIGHT_IDENTITY_RESET_EN
    for (int unsigned oc = 0; oc < OUT_CHANNELS; oc++) begin
      if (oc < IN_CHANNELS) begin
        bank[(((oc * IN_CHANNELS + oc) * KERNEL_SIZE + KERNEL_SIZE / 2) * KERNEL_SIZE
              + KERNEL_SIZE / 2) * WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_WIDTH'(1);
      end
    end
`endif
    return bank;
  endfunction

  localparam logic [BankWidth-1:0] DefaultBank = default_bank();

  state_e                  state_q, state_d;
  logic [CountWidth-1:0]   count_q;
  logic [BankWidth-1:0]    shadow_q;
  logic [BankWidth-1:0]    active_q;
  logic                    ready_en_q;
  logic                    error_q;
  logic                    xfer;
  logic                    accepting;
  logic                    at_last;

  assign xfer      = slave_tvalid_i & slave_tready_o;
  assign accepting = (state_q == IDLE) || (state_q == LOAD);
  assign at_last   = (count_q == LastIdx);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // IDLE behaves as LOAD with count 0, so a wrong-length set is caught from the first word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, LOAD: begin
        if (xfer) begin
          if (slave_tlast_i && at_last) state_d = PENDING;
          else if (slave_tlast_i)       state_d = IDLE;
          else if (at_last)             state_d = DRAIN;
          else                          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (xfer && slave_tlast_i) state_d = IDLE;
      end
      PENDING: begin
        if (frame_end_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slave_tready_o = 1'b0;
    busy_o         = 1'b1;
    pending_o      = 1'b0;
    commit_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        slave_tready_o = ready_en_q;
        busy_o         = 1'b0;
      end
      LOAD, DRAIN: begin
        slave_tready_o = ready_en_q;
      end
      PENDING: begin
        pending_o = 1'b1;
        commit_o  = frame_end_i;
      end
      default: busy_o = 1'b1;
    endcase
  end

  // Holds tready low for the cycle following reset release as well as during reset.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else if (state_d == LOAD) begin
      if (xfer) count_q <= count_q + 1'b1;
    end else begin
      count_q <= '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shadow_q <= '0;
    end else if (xfer && accepting) begin
      shadow_q[count_q * WEIGHT_WIDTH +: WEIGHT_WIDTH] <= slave_tdata_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      error_q <= 1'b0;
    end else if (xfer && accepting) begin
      if (slave_tlast_i && at_last)     error_q <= 1'b0;
      else if (slave_tlast_i || at_last) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      active_q <= DefaultBank;
    end else if (commit_o) begin
      active_q <= shadow_q;
    end
  end

  assign error_o  = error_q;
  assign weight_o = active_q;

endmodule

// File: tb/tb_convolution_weight_loader.sv
// Directed/randomised bench for convolution_weight_loader against an array-based model
// of the shadow and active banks.
module tb_convolution_weight_loader;

  localparam int W  = 8;
  localparam int K  = 3;
  localparam int IC = 3;
  localparam int OC = 3;
  localparam int NW = OC * IC * K * K;

  typedef logic [OC-1:0][IC-1:0][K-1:0][K-1:0][W-1:0] bank_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tvalid = 1'b0;
  logic tready;
  logic [W-1:0] tdata = '0;
  logic tlast = 1'b0;
  logic frame_end = 1'b0;
  bank_t weight;
  logic busy, pending, commit, error;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] act_m  [OC][IC][K][K];
  logic [W-1:0] shad_m [OC][IC][K][K];

  convolution_weight_loader #(
    .WEIGHT_WIDTH(W), .KERNEL_SIZE(K), .IN_CHANNELS(IC), .OUT_CHANNELS(OC)
  ) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .slave_tvalid_i(tvalid), .slave_tready_o(tready),
    .slave_tdata_i(tdata), .slave_tlast_i(tlast),
    .frame_end_i(frame_end), .weight_o(weight),
    .busy_o(busy), .pending_o(pending), .commit_o(commit), .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NW*W-1:0] obs, input logic [NW*W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bank_t pack_active();
    bank_t b;
    for (int oc = 0; oc < OC; oc++)
      for (int ic = 0; ic < IC; ic++)
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            b[oc][ic][i][j] = act_m[oc][ic][i][j];
    return b;
  endfunction

  task automatic set_default();
    for (int oc = 0; oc < OC; oc++)
      for (int ic = 0; ic < IC; ic++)
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) begin
            act_m[oc][ic][i][j] = '0;
`ifdef CONV_WEIGHT_IDENTITY_RESET_EN
            if (oc == ic && i == K / 2 && j == K / 2) act_m[oc][ic][i][j] = 8'd1;
`endif
          end
  endtask

  task automatic put_shadow(input int n, input logic [W-1:0] d);
    shad_m[n / (IC * K * K)][(n / (K * K)) % IC][(n / K) % K][n % K] = d;
  endtask

  task automatic commit_model();
    act_m = shad_m;
  endtask

  // Presents one word and returns at posedge+1 after it has been accepted.
  task automatic send_word(input logic [W-1:0] d, input logic last);
    int t;
    t = 0;
    tvalid = 1'b1; tdata = d; tlast = last;
    forever begin
      @(negedge clk);
      if (tready) break;
      t++;
      if (t > 200) begin
        check("tready_timeout", {31'd0, tready}, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_set(input int len, input logic with_last, input logic directed);
    logic [W-1:0] d;
    for (int n = 0; n < len; n++) begin
      d = directed ? W'(n - 40) : W'($urandom);
      if (n < NW) put_shadow(n, d);
      send_word(d, with_last && (n == len - 1));
    end
  endtask

  // Pulses frame_end_i for one cycle; returns at the following negedge.
  task automatic pulse_frame(input string tag, input logic expect_commit);
    frame_end = 1'b1;
    @(negedge clk);
    check({tag, "_commit"}, {31'd0, commit}, {31'd0, expect_commit});
    check({tag, "_w_before"}, weight, pack_active());
    @(posedge clk); #1;
    frame_end = 1'b0;
    if (expect_commit) commit_model();
    @(negedge clk);
    check({tag, "_commit_done"}, {31'd0, commit}, 32'd0);
    check({tag, "_w_after"}, weight, pack_active());
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_status(input string tag, input logic b, input logic p, input logic e);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, "_pending"}, {31'd0, pending}, {31'd0, p});
    check({tag, "_error"}, {31'd0, error}, {31'd0, e});
  endtask

  initial begin
    logic seen;
    set_default();
    shad_m = act_m;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_tready", {31'd0, tready}, 32'd0);
    check("rst_weight", weight, pack_active());
    check_status("rst", 1'b0, 1'b0, 1'b0);
    check("rst_commit", {31'd0, commit}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_tready", {31'd0, tready}, 32'd1);
    @(posedge clk); #1;

    // frame_end in IDLE is ignored.
    pulse_frame("idle_frame", 1'b0);
    @(posedge clk); #1;

    // Directed full load: word n = n-40.
    send_set(NW, 1'b1, 1'b1);
    @(negedge clk);
    check_status("full1", 1'b1, 1'b1, 1'b0);
    check("full1_tready", {31'd0, tready}, 32'd0);
    check("full1_w_held", weight, pack_active());
    @(posedge clk); #1;
    pulse_frame("full1", 1'b1);
    check("w2222", {{(NW*W-W){1'b0}}, weight[2][2][2][2]}, {{(NW*W-W){1'b0}}, 8'd40});
    check("w0000", {{(NW*W-W){1'b0}}, weight[0][0][0][0]}, {{(NW*W-W){1'b0}}, 8'hD8});
    @(posedge clk); #1;

    // Short set: tlast on word 10.
    send_set(10, 1'b1, 1'b0);
    @(negedge clk);
    check_status("short", 1'b0, 1'b0, 1'b1);
    check("short_w", weight, pack_active());
    @(posedge clk); #1;
    pulse_frame("short_frame", 1'b0);
    @(posedge clk); #1;
    send_set(NW, 1'b1, 1'b0);
    @(negedge clk);
    check_status("recover", 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    pulse_frame("recover", 1'b1);
    @(posedge clk); #1;

    // Over-length set: 85 words, tlast only on the last.
    send_set(NW, 1'b0, 1'b0);
    @(negedge clk);
    check_status("long_drain", 1'b1, 1'b0, 1'b1);
    check("long_tready", {31'd0, tready}, 32'd1);
    @(posedge clk); #1;
    for (int n = 0; n < 4; n++) send_word(W'($urandom), n == 3);
    @(negedge clk);
    check_status("long_end", 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    pulse_frame("long_frame", 1'b0);
    @(posedge clk); #1;

    // Final word coincides with frame_end: commit deferred to the next pulse.
    send_set(NW - 1, 1'b0, 1'b0);
    tvalid = 1'b1; tdata = W'($urandom); tlast = 1'b1; frame_end = 1'b1;
    put_shadow(NW - 1, tdata);
    @(negedge clk);
    check("same_tready", {31'd0, tready}, 32'd1);
    check("same_commit", {31'd0, commit}, 32'd0);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; frame_end = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (commit) seen = 1'b1;
    end
    check("same_no_commit", {31'd0, seen}, 32'd0);
    check_status("same_wait", 1'b1, 1'b1, 1'b0);
    check("same_w_held", weight, pack_active());
    @(posedge clk); #1;
    pulse_frame("same_late", 1'b1);
    @(posedge clk); #1;

    // Reset in the middle of a load.
    send_set(30, 1'b0, 1'b0);
    rst_n = 1'b0;
    set_default();
    #1;
    check("midrst_weight", weight, pack_active());
    check("midrst_tready", {31'd0, tready}, 32'd0);
    check_status("midrst", 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_set(NW, 1'b1, 1'b0);
    @(negedge clk);
    check_status("after_rst", 1'b1, 1'b1, 1'b0);
    check("after_rst_w_held", weight, pack_active());
    @(posedge clk); #1;
    pulse_frame("after_rst", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
